// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the BCD to gfedcba (active-low) table.
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ALL   = 7'h00;

  // Entry n holds the segment pattern for BCD digit n.
  localparam logic [9:0][6:0] BCD_SEG = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low gfedcba decode; codes 10..15 blank.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    for (int i = 0; i < 10; i++)
      if (nib == 4'(i)) seg = BCD_SEG[i];
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: prescaled digit scan with a dark
// slot per digit, per-digit blink, leading-zero blanking and alarm flash.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 2048,
  parameter int BLINK_DIV = 8388608
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic                blank_lz,
  input  logic                flash,
  input  logic                enable,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          seg,
  output logic [2:0]          scan_idx
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]     pre;
  logic [BW-1:0]     bcnt;
  logic              phase;
  logic              pre_tc, blink_tc;
  logic [3:0]        nib;
  logic              lz_zero, blink_on;
  logic [6:0]        dec_seg;
  logic [DIGITS-1:0] onehot;
  logic [DIGITS-1:0] anode_nxt;
  logic [6:0]        seg_nxt;

  assign pre_tc   = (pre == PW'(SCAN_DIV - 1));
  assign blink_tc = (bcnt == BW'(BLINK_DIV - 1));

  // Counters keep running while disabled so re-enable resumes mid-frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre      <= '0;
      scan_idx <= '0;
      bcnt     <= '0;
      phase    <= 1'b1;
    end else begin
      pre <= pre_tc ? '0 : pre + 1'b1;
      if (pre_tc)
        scan_idx <= (scan_idx == 3'(DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
      bcnt <= blink_tc ? '0 : bcnt + 1'b1;
      if (blink_tc) phase <= ~phase;
    end
  end

  // Select the addressed nibble and test whether it and all higher ones are zero.
  always_comb begin
    nib      = '0;
    blink_on = 1'b0;
    lz_zero  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (3'(i) == scan_idx) begin
        nib      = value[4*i +: 4];
        blink_on = blink_mask[i];
      end
      if (3'(i) >= scan_idx && value[4*i +: 4] != 4'd0) lz_zero = 1'b0;
    end
  end

  bcd_to_seg u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  assign onehot = ~(DIGITS'(1) << scan_idx);

  always_comb begin
    anode_nxt = '1;
    seg_nxt   = SEG_BLANK;
    if (!enable || pre_tc) begin
      anode_nxt = '1;
      seg_nxt   = SEG_BLANK;
    end else if (flash) begin
      if (phase) begin
        anode_nxt = onehot;
        seg_nxt   = SEG_ALL;
      end
    end else if (blink_on && !phase) begin
      anode_nxt = '1;
      seg_nxt   = SEG_BLANK;
    end else if (blank_lz && scan_idx != 3'd0 && lz_zero) begin
      anode_nxt = onehot;
      seg_nxt   = SEG_BLANK;
    end else begin
      anode_nxt = onehot;
      seg_nxt   = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      anode <= '1;
      seg   <= SEG_BLANK;
    end else begin
      anode <= anode_nxt;
      seg   <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4, BLINK_DIV=16.
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic        flash = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [2:0]  scan_idx;

  int tests = 0;
  int fails = 0;
  int k = 0;  // edges since the last reset release

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .resetn(resetn), .value(value), .blink_mask(blink_mask),
    .blank_lz(blank_lz), .flash(flash), .enable(enable),
    .anode(anode), .seg(seg), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  // Expected {anode, seg, scan_idx} after edge n, given per-digit lit patterns.
  function automatic logic [13:0] exp_out(input int n, input logic [3:0][6:0] ds,
                                          input logic [3:0] bm, input logic fl);
    int idx, pr, nidx;
    logic ph;
    logic [3:0] oh;
    idx  = ((n - 1) / 4) % 4;
    pr   = (n - 1) % 4;
    nidx = (n / 4) % 4;
    ph   = (((n - 1) / 16) % 2) == 0;
    oh   = 4'b1111 & ~(4'b0001 << idx);
    if (pr == 3)             return {4'b1111, 7'h7F, 3'(nidx)};
    if (fl)                  return ph ? {oh, 7'h00, 3'(nidx)} : {4'b1111, 7'h7F, 3'(nidx)};
    if (bm[idx] && !ph)      return {4'b1111, 7'h7F, 3'(nidx)};
    return {oh, ds[idx], 3'(nidx)};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s k=%0d observed anode/seg/idx=%b/%h/%0d expected %b/%h/%0d",
             tag, k, got[13:10], got[9:3], got[2:0], exp[13:10], exp[9:3], exp[2:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("reset", {anode, seg, scan_idx}, {4'b1111, 7'h7F, 3'd0});
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
  endtask

  task automatic run(input string tag, input int n, input logic [3:0][6:0] ds,
                     input logic [3:0] bm, input logic fl);
    repeat (n) begin
      step();
      check(tag, {anode, seg, scan_idx}, exp_out(k, ds, bm, fl));
    end
  endtask

  initial begin
    // 1: plain scan of 1234
    value = 16'h1234;
    do_reset();
    run("scan1234", 32, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, 1'b0);

    // 2: leading-zero blanking
    blank_lz = 1'b1;
    value = 16'h0007;
    do_reset();
    run("lz0007", 16, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b0000, 1'b0);
    value = 16'h0000;
    do_reset();
    run("lz0000", 16, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000, 1'b0);
    value = 16'h0700;
    do_reset();
    run("lz0700", 16, {7'h7F, 7'h78, 7'h40, 7'h40}, 4'b0000, 1'b0);

    // 3: blink digits 0 and 1
    blank_lz = 1'b0;
    value = 16'h1234;
    blink_mask = 4'b0011;
    do_reset();
    run("blink", 64, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0011, 1'b0);
    blink_mask = 4'b0000;

    // 4: flash overrides leading-zero blanking
    blank_lz = 1'b1;
    value = 16'h0000;
    flash = 1'b1;
    do_reset();
    run("flash", 48, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000, 1'b1);
    flash = 1'b0;
    blank_lz = 1'b0;

    // 5: invalid nibble, then enable off/on
    value = 16'h00A0;
    do_reset();
    run("bad_nib", 8, {7'h40, 7'h40, 7'h7F, 7'h40}, 4'b0000, 1'b0);
    enable = 1'b0;
    repeat (8) begin
      step();
      check("disabled", {anode, seg, scan_idx}, {4'b1111, 7'h7F, 3'((k / 4) % 4)});
    end
    enable = 1'b1;
    run("reenable", 16, {7'h40, 7'h40, 7'h7F, 7'h40}, 4'b0000, 1'b0);

    // 6: reset mid-frame at scan_idx 2
    value = 16'h1234;
    do_reset();
    run("pre_rst", 10, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, 1'b0);
    check("at_idx2", {11'h0, scan_idx}, {11'h0, 3'd2});
    #2;
    resetn = 1'b0;
    #1;
    check("midreset", {anode, seg, scan_idx}, {4'b1111, 7'h7F, 3'd0});
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
    run("restart", 32, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
